arbitro_divisor: RTL and testbench
==================================

Name: arbitro_divisor

Overview:
- Shares one `divisor` instance between NUM_SOL requesters, e.g. calculator front-ends or operation units.
- Each requester offers a 16-bit dividend/divisor pair through a valid/ready handshake.
- Requests are served in round-robin order. The block drives the divider's start, waits for its done pulse, and returns the quotient and remainder to the winning requester.
- It sits between the operation decoders and the single divider datapath.

Parameters:
- NUM_SOL, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_SOL), width of the requester index; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sol_valido  in  NUM_SOL  request valid, one bit per requester; held with operands until accepted.
- sol_dividendo  in  NUM_SOL*16  packed dividends; requester i uses bits [16i+15:16i].
- sol_divisor  in  NUM_SOL*16  packed divisors, same packing.
- sol_listo  out  NUM_SOL  accept; one-hot, one cycle.
- res_valido  out  NUM_SOL  result valid; one-hot, one-cycle pulse to the owner.
- res_cociente  out  16  quotient, shared bus.
- res_residuo  out  16  remainder, shared bus.
- res_id  out  ID_W  index of the current owner.
- ocupado  out  1  high whenever the state is not LIBRE.
- div_iniciar  out  1  start pulse to the divider.
- div_dividendo  out  16  registered operand, stable from accept until done.
- div_divisor  out  16  registered operand, stable from accept until done.
- div_cociente  in  32  divider result: [15:0] quotient, [31:16] remainder.
- div_terminado  in  1  divider done pulse, one cycle.

Behaviour:
- Reset: async on rst_n low. State LIBRE, pointer=0; all outputs, operand registers and result registers 0.
- FSM states: LIBRE, LANZAR, ESPERAR, ENTREGAR.
- LIBRE:
  - Winner = first i with sol_valido[i]=1, searching from pointer upward with wrap.
  - sol_listo[winner]=1 combinationally in the same cycle.
  - At the edge: capture operands and res_id=winner; set pointer=(winner+1) mod NUM_SOL; go to LANZAR.
  - No request: stay; pointer unchanged.
- LANZAR: div_iniciar=1 for exactly one cycle; go to ESPERAR.
- ESPERAR:
  - On div_terminado=1, register quotient and remainder from div_cociente; go to ENTREGAR.
  - No timeout.
  - Any div_terminado seen outside ESPERAR is ignored.
- ENTREGAR: res_valido[res_id]=1 for one cycle; go to LIBRE.
  - res_cociente, res_residuo and res_id stay unchanged until the next capture.
- Only one operation is outstanding at a time. sol_listo is never asserted outside LIBRE.
- Requests arriving during a busy period wait; they are not dropped.
- A requester may re-assert sol_valido in its own res_valido cycle. It is then arbitrated in the next LIBRE cycle, behind any higher-priority requesters per the pointer.
- Latency from accept to res_valido = divider latency + 3 cycles.
- Reset mid-operation: aborts immediately and returns to LIBRE. The divider shares rst_n; the in-flight result is discarded and no res_valido is issued.
- sol_valido dropping before accept is legal; the request is simply not served.

Optional Feature:
- Macro DIV_CERO_EN.
  - Defined, divisor==0 at accept: skip LANZAR/ESPERAR and go straight to ENTREGAR with quotient=16'hFFFF and remainder=dividend. Extra output res_div_cero (1 bit) is high in that ENTREGAR cycle, else 0. Latency is 2 cycles.
  - Undefined: zero divisors go to the divider. It produces the same 16'hFFFF/dividend values at normal latency. Port res_div_cero is absent.

Decomposition:
- Package arbitro_pkg holds:
  - the estados_arb_t enum (LIBRE, LANZAR, ESPERAR, ENTREGAR);
  - localparam ANCHO_OP=16;
  - localparam ANCHO_RES=32.
- One sub-module, rr_selector: combinational round-robin priority pick.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, winner index, any_request.

Test Plan:
- Req0 with 100/7 → sol_listo[0] in the same cycle; div_iniciar one cycle later; res_valido[0] with res_cociente=14, res_residuo=2.
- All four request continuously with 16'd(10*i+9)/3 → grant order 0,1,2,3,0; each res_valido one-hot with the matching quotient.
- Req2 with 65535/1 while req1 arrives mid-ESPERAR → req2 gets 65535 rem 0; then req1 is served; ocupado stays high across both.
- Divisor 0, dividend 1234 → quotient 16'hFFFF, remainder 1234. With DIV_CERO_EN: res_div_cero=1, latency 2, div_iniciar never pulses.
- rst_n low during ESPERAR → state LIBRE and all outputs 0 asynchronously; no res_valido. A new request after release completes correctly.

Source files
------------

// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared FSM states and operand/result widths for the divider arbiter.
package arbitro_pkg;

    typedef enum logic [1:0] {
        LIBRE,
        LANZAR,
        ESPERAR,
        ENTREGAR
    } estados_arb_t;

    localparam int ANCHO_OP  = 16;
    localparam int ANCHO_RES = 32;

endpackage

// File: rtl/arbitro_divisor_rr_selector.sv
// rr_selector: combinational round-robin pick of the first active request at or after the pointer.
module rr_selector #(
    parameter  int NUM_SOL = 4,
    localparam int ID_W    = $clog2(NUM_SOL)
) (
    input  logic [NUM_SOL-1:0] sol_i,
    input  logic [ID_W-1:0]    puntero_i,
    output logic [NUM_SOL-1:0] concesion_o,
    output logic [ID_W-1:0]    ganador_o,
    output logic               hay_sol_o
);

    logic [ID_W:0]   suma;
    logic [ID_W-1:0] cand;

    // Walk offsets from farthest to nearest so the closest request to the pointer wins last.
    always_comb begin
        suma      = '0;
        cand      = '0;
        ganador_o = '0;
        for (int k = NUM_SOL - 1; k >= 0; k--) begin
            suma = {1'b0, puntero_i} + (ID_W+1)'(k);
            cand = (suma >= (ID_W+1)'(NUM_SOL)) ? ID_W'(suma - (ID_W+1)'(NUM_SOL)) : suma[ID_W-1:0];
            if (sol_i[cand]) ganador_o = cand;
        end
    end

    assign hay_sol_o   = |sol_i;
    assign concesion_o = hay_sol_o ? ({{(NUM_SOL-1){1'b0}}, 1'b1} << ganador_o) : '0;

endmodule

// File: rtl/arbitro_divisor.sv
// arbitro_divisor: round-robin sharing of one divider among NUM_SOL requesters (optional DIV_CERO_EN bypass for zero divisors).
module arbitro_divisor
    import arbitro_pkg::*;
#(
    parameter  int NUM_SOL = 4,
    localparam int ID_W    = $clog2(NUM_SOL)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SOL-1:0]          sol_valido,
    input  logic [NUM_SOL*ANCHO_OP-1:0] sol_dividendo,
    input  logic [NUM_SOL*ANCHO_OP-1:0] sol_divisor,
    output logic [NUM_SOL-1:0]          sol_listo,
    output logic [NUM_SOL-1:0]          res_valido,
    output logic [ANCHO_OP-1:0]         res_cociente,
    output logic [ANCHO_OP-1:0]         res_residuo,
    output logic [ID_W-1:0]             res_id,
    output logic                        ocupado,
`ifdef DIV_CERO_EN
    output logic                        res_div_cero,
`endif
    output logic                        div_iniciar,
    output logic [ANCHO_OP-1:0]         div_dividendo,
    output logic [ANCHO_OP-1:0]         div_divisor,
    input  logic [ANCHO_RES-1:0]        div_cociente,
    input  logic                        div_terminado
);

    estados_arb_t        estado_q, estado_d;
    logic [ID_W-1:0]     puntero_q, puntero_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ANCHO_OP-1:0] dvd_q, dvd_d;
    logic [ANCHO_OP-1:0] dvs_q, dvs_d;
    logic [ANCHO_OP-1:0] coc_q, coc_d;
    logic [ANCHO_OP-1:0] res_q, res_d;
`ifdef DIV_CERO_EN
    logic                cero_q, cero_d;
`endif

    logic [NUM_SOL-1:0]  concesion;
    logic [ID_W-1:0]     ganador;
    logic                hay_sol;
    logic [ANCHO_OP-1:0] dvd_sel, dvs_sel;

    rr_selector #(.NUM_SOL(NUM_SOL)) u_sel (
        .sol_i       (sol_valido),
        .puntero_i   (puntero_q),
        .concesion_o (concesion),
        .ganador_o   (ganador),
        .hay_sol_o   (hay_sol)
    );

    assign dvd_sel = sol_dividendo[ganador*ANCHO_OP +: ANCHO_OP];
    assign dvs_sel = sol_divisor[ganador*ANCHO_OP +: ANCHO_OP];

    // State, pointer, operand and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= LIBRE;
            puntero_q <= '0;
            id_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            coc_q     <= '0;
            res_q     <= '0;
`ifdef DIV_CERO_EN
            cero_q    <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            puntero_q <= puntero_d;
            id_q      <= id_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            coc_q     <= coc_d;
            res_q     <= res_d;
`ifdef DIV_CERO_EN
            cero_q    <= cero_d;
`endif
        end
    end

    // Next state: accept in LIBRE, pulse start, wait for done, deliver for one cycle.
    always_comb begin
        estado_d  = estado_q;
        puntero_d = puntero_q;
        id_d      = id_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        coc_d     = coc_q;
        res_d     = res_q;
`ifdef DIV_CERO_EN
        cero_d    = cero_q;
`endif
        case (estado_q)
            LIBRE: if (hay_sol) begin
                estado_d  = LANZAR;
                id_d      = ganador;
                puntero_d = (ganador == ID_W'(NUM_SOL - 1)) ? '0 : ganador + 1'b1;
                dvd_d     = dvd_sel;
                dvs_d     = dvs_sel;
`ifdef DIV_CERO_EN
                cero_d    = (dvs_sel == '0);
                if (dvs_sel == '0) begin
                    estado_d = ENTREGAR;
                    coc_d    = '1;
                    res_d    = dvd_sel;
                end
`endif
            end
            LANZAR:  estado_d = ESPERAR;
            ESPERAR: if (div_terminado) begin
                estado_d = ENTREGAR;
                coc_d    = div_cociente[ANCHO_OP-1:0];
                res_d    = div_cociente[ANCHO_RES-1:ANCHO_OP];
            end
            ENTREGAR: estado_d = LIBRE;
            default:  estado_d = LIBRE;
        endcase
    end

    assign sol_listo     = (estado_q == LIBRE && rst_n) ? concesion : '0;
    assign res_valido    = (estado_q == ENTREGAR) ? ({{(NUM_SOL-1){1'b0}}, 1'b1} << id_q) : '0;
    assign ocupado       = (estado_q != LIBRE);
    assign div_iniciar   = (estado_q == LANZAR);
    assign div_dividendo = dvd_q;
    assign div_divisor   = dvs_q;
    assign res_cociente  = coc_q;
    assign res_residuo   = res_q;
    assign res_id        = id_q;
`ifdef DIV_CERO_EN
    assign res_div_cero  = (estado_q == ENTREGAR) && cero_q;
`endif

endmodule

// File: tb/tb_arbitro_divisor.sv
// tb_arbitro_divisor: directed checks of the divider arbiter against a behavioural divider with fixed latency.
module tb_arbitro_divisor;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  sol_valido = '0;
    logic [N*16-1:0] sol_dividendo = '0;
    logic [N*16-1:0] sol_divisor = '0;
    logic [N-1:0]  sol_listo, res_valido;
    logic [15:0]   res_cociente, res_residuo;
    logic [1:0]    res_id;
    logic          ocupado, div_iniciar;
    logic [15:0]   div_dividendo, div_divisor;
    logic [31:0]   div_cociente;
    logic          div_terminado;
    logic          espurio = 1'b0;
`ifdef DIV_CERO_EN
    logic          res_div_cero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arbitro_divisor #(.NUM_SOL(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sol_valido    (sol_valido),
        .sol_dividendo (sol_dividendo),
        .sol_divisor   (sol_divisor),
        .sol_listo     (sol_listo),
        .res_valido    (res_valido),
        .res_cociente  (res_cociente),
        .res_residuo   (res_residuo),
        .res_id        (res_id),
        .ocupado       (ocupado),
`ifdef DIV_CERO_EN
        .res_div_cero  (res_div_cero),
`endif
        .div_iniciar   (div_iniciar),
        .div_dividendo (div_dividendo),
        .div_divisor   (div_divisor),
        .div_cociente  (div_cociente),
        .div_terminado (div_terminado)
    );

    // Behavioural divider: done is high LAT cycles after the start cycle.
    int cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0;
            div_cociente <= '0;
        end else if (div_iniciar) begin
            cnt <= LAT;
            div_cociente <= (div_divisor == 0) ? {div_dividendo, 16'hFFFF}
                                               : {div_dividendo % div_divisor, div_dividendo / div_divisor};
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign div_terminado = (cnt == 1) || espurio;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [15:0] dvd, input logic [15:0] dvs);
        sol_valido[i] = v;
        sol_dividendo[16*i +: 16] = dvd;
        sol_divisor[16*i +: 16] = dvs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until res_valido shows up; report edges taken and start pulses seen.
    task automatic wait_res(input string tag, output int n, output int ini);
        n = 0;
        ini = 0;
        do begin
            step();
            n++;
            if (div_iniciar) ini++;
        end while (res_valido == '0 && n < 60);
        if (res_valido == '0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n, ini;
        logic [15:0] e_coc [4];
        logic [15:0] e_res [4];
        e_coc = '{16'd3, 16'd6, 16'd9, 16'd13};
        e_res = '{16'd0, 16'd1, 16'd2, 16'd0};

        #12;
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_listo", 32'(sol_listo), 0);
        chk("rst_res_valido", 32'(res_valido), 0);
        chk("rst_iniciar", 32'(div_iniciar), 0);
        chk("rst_res", {res_residuo, res_cociente}, 0);
        step();
        rst_n = 1'b1;
        step();

        set_req(0, 1, 16'd100, 16'd7);
        #1;
        chk("t1_listo", 32'(sol_listo), 32'b0001);
        step();
        set_req(0, 0, 16'd100, 16'd7);
        chk("t1_iniciar", 32'(div_iniciar), 1);
        chk("t1_op", {div_dividendo, div_divisor}, {16'd100, 16'd7});
        chk("t1_listo_busy", 32'(sol_listo), 0);
        wait_res("t1", n, ini);
        chk("t1_latencia", n, LAT + 1);
        chk("t1_valido", 32'(res_valido), 32'b0001);
        chk("t1_res", {res_residuo, res_cociente}, {16'd2, 16'd14});
        step();
        chk("t1_valido_pulso", 32'(res_valido), 0);
        espurio = 1'b1;
        step();
        espurio = 1'b0;
        step();
        chk("t1_espurio", {31'd0, ocupado}, 0);
        chk("t1_res_hold", {res_residuo, res_cociente}, {16'd2, 16'd14});

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1, 16'(10 * i + 9), 16'd3);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t2_listo%0d", k), 32'(sol_listo), 32'(1 << (k % N)));
            wait_res($sformatf("t2_%0d", k), n, ini);
            chk($sformatf("t2_valido%0d", k), 32'(res_valido), 32'(1 << (k % N)));
            chk($sformatf("t2_coc%0d", k), {res_residuo, res_cociente}, {e_res[k % N], e_coc[k % N]});
            step();
        end
        sol_valido = '0;
        step();

        set_req(2, 1, 16'd65535, 16'd1);
        #1;
        chk("t3_listo2", 32'(sol_listo), 32'b0100);
        step();
        set_req(2, 0, 16'd65535, 16'd1);
        step();
        step();
        set_req(1, 1, 16'd50, 16'd6);
        #1;
        chk("t3_listo_espera", 32'(sol_listo), 0);
        chk("t3_ocupado", 32'(ocupado), 1);
        wait_res("t3a", n, ini);
        chk("t3_valido2", 32'(res_valido), 32'b0100);
        chk("t3_res2", {res_residuo, res_cociente}, {16'd0, 16'd65535});
        step();
        chk("t3_listo1", 32'(sol_listo), 32'b0010);
        step();
        set_req(1, 0, 16'd50, 16'd6);
        wait_res("t3b", n, ini);
        chk("t3_valido1", 32'(res_valido), 32'b0010);
        chk("t3_res1", {res_residuo, res_cociente}, {16'd2, 16'd8});
        step();

        set_req(3, 1, 16'd1234, 16'd0);
        #1;
        chk("t4_listo3", 32'(sol_listo), 32'b1000);
        wait_res("t4", n, ini);
        set_req(3, 0, 16'd1234, 16'd0);
        chk("t4_valido", 32'(res_valido), 32'b1000);
        chk("t4_res", {res_residuo, res_cociente}, {16'd1234, 16'hFFFF});
`ifdef DIV_CERO_EN
        chk("t4_latencia", n, 1);
        chk("t4_iniciar", ini, 0);
        chk("t4_cero", 32'(res_div_cero), 1);
`else
        chk("t4_latencia", n, LAT + 2);
        chk("t4_iniciar", ini, 1);
`endif
        step();

        set_req(0, 1, 16'd50, 16'd5);
        #1;
        chk("t5_listo0", 32'(sol_listo), 32'b0001);
        step();
        set_req(0, 0, 16'd50, 16'd5);
        step();
        step();
        chk("t5_esperando", 32'(ocupado), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ocupado", 32'(ocupado), 0);
        chk("t5_rst_valido", 32'(res_valido), 0);
        chk("t5_rst_res", {res_residuo, res_cociente}, 0);
        chk("t5_rst_op", {div_dividendo, div_divisor}, 0);
        chk("t5_rst_id", 32'(res_id), 0);
        step();
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (res_valido != '0 || ocupado) n++;
        end
        chk("t5_sin_resultado", n, 0);
        set_req(1, 1, 16'd200, 16'd9);
        #1;
        chk("t5_listo1", 32'(sol_listo), 32'b0010);
        step();
        set_req(1, 0, 16'd200, 16'd9);
        wait_res("t5", n, ini);
        chk("t5_valido", 32'(res_valido), 32'b0010);
        chk("t5_res", {res_residuo, res_cociente}, {16'd2, 16'd22});
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
